// File: rtl/i2s_tx_framer.sv
// I2S transmit framer: pulls FIFO bits and drives sd/ws, registered one sclk behind the internal bit counter.
// No backpressure upstream; an empty FIFO at word start turns that whole word into fill and raises sticky underrun.
module i2s_tx_framer #(
    parameter int   SLOT_MAX      = 32,
    parameter logic UNDERRUN_FILL = 1'b0
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_size,
    input  logic [1:0] word_size,
    input  logic [1:0] standard,
    input  logic       stereo,
    input  logic       mute,
    input  logic       clr_underrun,
    input  logic       fifo_bit,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       sd,
    output logic       ws,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam int CW = $clog2(SLOT_MAX);
    localparam logic [CW:0] LEN16 = 16;
    localparam logic [CW:0] LEN24 = 24;
    localparam logic [CW:0] LEN32 = 32;
    localparam logic [CW:0] ONE   = 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          slot, slot_nxt;

    logic [CW-1:0] cfg_last, cfg_off, cfg_wend;
    logic          cfg_philips, cfg_stereo;
    logic          word_ok;

    logic [CW:0]   len, wlen, t_last, t_off, t_wend;
    logic [CW-1:0] new_last, new_off, new_wend;

    logic run, at_last, win, word_start, ok_now, frame_end, latch;
    logic sd_nxt, ws_nxt;

    // Window bounds are precomputed at latch time so the per-bit compare is just two magnitude checks.
    always_comb begin
        len  = frame_size ? LEN32 : LEN16;
        case (word_size)
            2'd0:    wlen = LEN16;
            2'd1:    wlen = LEN24;
            default: wlen = LEN32;
        endcase
        if (wlen > len) wlen = len;
        t_last = len - ONE;
        if (standard[1]) begin
            t_off  = len - wlen;
            t_wend = t_last;
        end else begin
            t_off  = '0;
            t_wend = wlen - ONE;
        end
        new_last = t_last[CW-1:0];
        new_off  = t_off[CW-1:0];
        new_wend = t_wend[CW-1:0];
    end

    assign run        = (state == RUN);
    assign busy       = run;
    assign at_last    = (cnt == cfg_last);
    assign win        = (!slot || cfg_stereo) && (cnt >= cfg_off) && (cnt <= cfg_wend);
    assign word_start = win && (cnt == cfg_off);
    assign ok_now     = word_start ? !fifo_empty : word_ok;
    assign frame_end  = run && at_last && slot;
    assign latch      = en && (!run || frame_end);
    assign fifo_rd_en = run && win && ok_now && !rst;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slot_nxt  = slot;
        sd_nxt    = 1'b0;
        ws_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    slot_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (at_last) begin
                    cnt_nxt  = '0;
                    slot_nxt = !slot;
                    if (slot && !en) state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (win && !mute) sd_nxt = ok_now ? fifo_bit : UNDERRUN_FILL;
                ws_nxt = slot ^ (cfg_philips && at_last);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            slot        <= 1'b0;
            sd          <= 1'b0;
            ws          <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
            word_ok     <= 1'b0;
            cfg_last    <= '0;
            cfg_off     <= '0;
            cfg_wend    <= '0;
            cfg_philips <= 1'b0;
            cfg_stereo  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            slot       <= slot_nxt;
            sd         <= sd_nxt;
            ws         <= ws_nxt;
            frame_done <= frame_end;
            if (run && word_start) word_ok <= !fifo_empty;
            if (run && word_start && fifo_empty) underrun <= 1'b1;
            else if (clr_underrun)               underrun <= 1'b0;
            if (latch) begin
                cfg_last    <= new_last;
                cfg_off     <= new_off;
                cfg_wend    <= new_wend;
                cfg_philips <= (standard == 2'd0);
                cfg_stereo  <= stereo;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_framer.sv
// Directed bench for i2s_tx_framer: a bit-serial FIFO model feeds the DUT, per-cycle outputs are recorded
// and compared against hand-derived bit patterns.
module tb_i2s_tx_framer;
    logic       sclk = 1'b0;
    logic       rst, en, frame_size, stereo, mute, clr_underrun, fifo_bit, fifo_empty;
    logic [1:0] word_size, standard;
    logic       fifo_rd_en, sd, ws, busy, frame_done, underrun;

    i2s_tx_framer dut (
        .sclk(sclk), .rst(rst), .en(en), .frame_size(frame_size), .word_size(word_size),
        .standard(standard), .stereo(stereo), .mute(mute), .clr_underrun(clr_underrun),
        .fifo_bit(fifo_bit), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .sd(sd), .ws(ws),
        .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 sclk = ~sclk;

    localparam int SD = 0, WS = 1, RD = 2, FD = 3, BZ = 4, UR = 5;

    logic        sd_t [0:299];
    logic        ws_t [0:299];
    logic        rd_t [0:299];
    logic        fd_t [0:299];
    logic        bz_t [0:299];
    logic        ur_t [0:299];
    logic [31:0] q_dat [$];
    int          q_w   [$];
    int          bit_idx = 0;
    int          errors  = 0;
    int          checks  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void fifo_drive();
        logic [31:0] w;
        fifo_empty = (q_dat.size() == 0);
        if (q_dat.size() == 0) fifo_bit = 1'b0;
        else begin
            w        = q_dat[0];
            fifo_bit = w[q_w[0] - 1 - bit_idx];
        end
    endfunction

    function automatic void push(input logic [31:0] w, input int n);
        q_dat.push_back(w);
        q_w.push_back(n);
        fifo_drive();
    endfunction

    function automatic void fifo_advance();
        if (q_dat.size() == 0) return;
        bit_idx++;
        if (bit_idx == q_w[0]) begin
            void'(q_dat.pop_front());
            void'(q_w.pop_front());
            bit_idx = 0;
        end
    endfunction

    // Records what is visible just before the edge, then consumes a FIFO bit if rd_en was high at that edge.
    task automatic step_rec(input int i);
        logic took;
        #1;
        sd_t[i] = sd; ws_t[i] = ws; rd_t[i] = fifo_rd_en;
        fd_t[i] = frame_done; bz_t[i] = busy; ur_t[i] = underrun;
        took = (fifo_rd_en === 1'b1);
        @(posedge sclk);
        @(negedge sclk);
        if (took) fifo_advance();
        fifo_drive();
    endtask

    function automatic logic [63:0] pick(input int sel, input int s, input int n);
        logic [63:0] r;
        logic        b;
        r = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                SD:      b = sd_t[s + i];
                WS:      b = ws_t[s + i];
                RD:      b = rd_t[s + i];
                FD:      b = fd_t[s + i];
                BZ:      b = bz_t[s + i];
                default: b = ur_t[s + i];
            endcase
            r = {r[62:0], b};
        end
        return r;
    endfunction

    function automatic int count_fd(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (fd_t[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic logic [5:0] outs(input int i);
        return {sd_t[i], ws_t[i], rd_t[i], bz_t[i], fd_t[i], ur_t[i]};
    endfunction

    task automatic set_cfg(input logic fs, input logic [1:0] wsz, input logic [1:0] std,
                           input logic st, input logic mu);
        frame_size = fs; word_size = wsz; standard = std; stereo = st; mute = mu;
    endtask

    // Runs n cycles with en high for the first en_len of them.
    task automatic run(input int n, input int en_len);
        for (int i = 0; i < n; i++) begin
            en = (i < en_len);
            step_rec(i);
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr_underrun = 1'b0;
        set_cfg(1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
        fifo_drive();
        step_rec(0);
        step_rec(1);
        chk("reset_outputs", {58'd0, outs(1)}, 64'd0);
        rst = 1'b0;
        step_rec(0);

        // MSB-justified, 16/16 stereo
        push(32'hA5C3, 16); push(32'h0F0F, 16);
        run(40, 1);
        chk("msb_rd", pick(RD, 0, 34), 64'h1_FFFF_FFFE);
        chk("msb_sd", pick(SD, 2, 32), 64'hA5C3_0F0F);
        chk("msb_ws", pick(WS, 2, 32), 64'h0000_FFFF);
        chk("msb_fd_at", {63'd0, fd_t[33]}, 64'd1);
        chk("msb_fd_count", count_fd(40), 64'd1);
        chk("msb_busy_fall", pick(BZ, 32, 2), 64'b10);
        chk("msb_idle_ws_sd", pick(WS, 34, 1) << 1 | pick(SD, 34, 1), 64'd0);
        chk("msb_no_underrun", pick(UR, 0, 40), 64'd0);

        // Philips, 32-bit slot, 24-bit words, two frames
        set_cfg(1'b1, 2'd1, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) push(32'hABCDEF, 24);
        run(135, 70);
        chk("phil_rd_left", pick(RD, 1, 32), 64'hFFFF_FF00);
        chk("phil_rd_right", pick(RD, 33, 32), 64'hFFFF_FF00);
        chk("phil_sd_left", pick(SD, 2, 32), 64'hABCD_EF00);
        chk("phil_ws_rise", pick(WS, 32, 4), 64'b0111);
        chk("phil_ws_fall", pick(WS, 63, 4), 64'b1100);
        chk("phil_msb_after_ws", pick(SD, 66, 1), 64'd1);
        chk("phil_fd_count", count_fd(135), 64'd2);
        chk("phil_fifo_drained", q_dat.size(), 64'd0);

        // LSB-justified, 32-bit slot, 16-bit words
        set_cfg(1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
        push(32'h8001, 16); push(32'h8001, 16);
        run(70, 1);
        chk("lsb_rd", pick(RD, 1, 32), 64'h0000_FFFF);
        chk("lsb_sd", pick(SD, 2, 32), 64'h0000_8001);
        chk("lsb_ws_toggle", pick(WS, 32, 3), 64'b001);
        chk("lsb_last_bit", pick(SD, 33, 1), 64'd1);

        // Word longer than slot is clamped to 16 bits
        set_cfg(1'b0, 2'd2, 2'd1, 1'b1, 1'b0);
        push(32'h1357, 16); push(32'h9BDF, 16);
        run(40, 1);
        chk("clamp_rd", pick(RD, 0, 34), 64'h1_FFFF_FFFE);
        chk("clamp_sd", pick(SD, 2, 32), 64'h1357_9BDF);

        // Underrun on the left word, right word recovers
        set_cfg(1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            en = (i < 1);
            if (i == 5) push(32'h1234, 16);
            step_rec(i);
        end
        en = 1'b0;
        chk("ur_set", pick(UR, 2, 1), 64'd1);
        chk("ur_rd_left", pick(RD, 1, 16), 64'd0);
        chk("ur_sd_left", pick(SD, 2, 16), 64'd0);
        chk("ur_rd_right", pick(RD, 17, 16), 64'hFFFF);
        chk("ur_sd_right", pick(SD, 18, 16), 64'h1234);
        chk("ur_sticky", pick(UR, 39, 1), 64'd1);
        clr_underrun = 1'b1;
        step_rec(0);
        clr_underrun = 1'b0;
        step_rec(1);
        chk("ur_cleared", pick(UR, 1, 1), 64'd0);

        // Mono: right slot silent and unread
        set_cfg(1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
        push(32'hFFFF, 16); push(32'hFFFF, 16);
        run(40, 1);
        chk("mono_rd", pick(RD, 1, 32), 64'hFFFF_0000);
        chk("mono_sd", pick(SD, 2, 32), 64'hFFFF_0000);

        // Mute: words consumed, line silent
        set_cfg(1'b0, 2'd0, 2'd1, 1'b1, 1'b1);
        push(32'hFFFF, 16);
        run(40, 1);
        chk("mute_rd", pick(RD, 1, 32), 64'hFFFF_FFFF);
        chk("mute_sd", pick(SD, 2, 32), 64'd0);
        chk("mute_drained", q_dat.size(), 64'd0);

        // en drops at cnt 5: frame still completes
        set_cfg(1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
        push(32'hC001, 16); push(32'h8003, 16);
        run(40, 6);
        chk("stop_sd", pick(SD, 2, 32), 64'hC001_8003);
        chk("stop_fd", pick(FD, 32, 3), 64'b010);
        chk("stop_busy", pick(BZ, 32, 2), 64'b10);
        chk("stop_ws_idle", pick(WS, 34, 1), 64'd0);

        // Reset mid right slot with underrun pending
        for (int i = 0; i < 20; i++) begin
            en = 1'b1;
            if (i == 5) push(32'hFFFF, 16);
            step_rec(i);
        end
        rst = 1'b1;
        step_rec(20);
        step_rec(21);
        chk("rst_pre_state", {61'd0, sd_t[20], ws_t[20], ur_t[20]}, 64'b111);
        chk("rst_mid_slot", {58'd0, outs(21)}, 64'd0);
        rst = 1'b0; en = 1'b0;
        q_dat.delete(); q_w.delete(); bit_idx = 0;
        fifo_drive();
        step_rec(22);
        chk("rst_stays_idle", {58'd0, outs(22)}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
